regfile_mp: RTL and testbench

- Parametrised successor to the MIPS 32x32 register file.
- Provides NUM_RD combinational read ports and two clocked write ports with fixed priority.
- Optional write-to-read bypass; optional hardwired zero register.
- Per-register busy scoreboard for pipeline hazard detection; storage is cleared by a sequential init sweep after reset.
- Sits in the decode stage of the pipelined MIPS core; the writeback and issue logic drive it.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_rd_mux.sv | 47 ++++
 rtl/regfile_mp.sv | 114 +++++++++++
 tb/tb_regfile_mp.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port MIPS register file: FSM encoding and
// the default geometry used by the core.
package regfile_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int unsigned MIPS_DW = 32;
  localparam int unsigned MIPS_AW = 5;

endpackage

// File: rtl/regfile_rd_mux.sv
// One combinational read port: address decode, zero-register suppression and
// write-to-read bypass (port 1 wins over port 0).
module regfile_rd_mux
  import regfile_pkg::*;
#(
  parameter int unsigned DW       = MIPS_DW,
  parameter int unsigned AW       = MIPS_AW,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                 run,
  input  logic [AW-1:0]        ra,
  input  logic [DW-1:0]        mem [2**AW],
  input  logic [(2**AW)-1:0]   busy,
  input  logic                 we0,
  input  logic [AW-1:0]        wa0,
  input  logic [DW-1:0]        wd0,
  input  logic                 we1,
  input  logic [AW-1:0]        wa1,
  input  logic [DW-1:0]        wd1,
  output logic [DW-1:0]        rd,
  output logic                 rbusy
);

  localparam bit ZR  = (ZERO_REG != 0);
  localparam bit BYP = (BYPASS != 0);

  logic suppress;

  always_comb begin
    suppress = ZR && (ra == '0);
    rd       = '0;
    rbusy    = 1'b0;
    if (run && !suppress) begin
      rd    = mem[ra];
      rbusy = busy[ra];
      if (BYP) begin
        if (we1 && (wa1 == ra)) begin
          rd = wd1;
        end else if (we0 && (wa0 == ra)) begin
          rd = wd0;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with clear-on-reset sweep and per-register busy
// scoreboard; read ports are instances of regfile_rd_mux.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DW       = MIPS_DW,
  parameter int unsigned AW       = MIPS_AW,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_RD*AW-1:0] ra,
  output logic [NUM_RD*DW-1:0] rd,
  output logic [NUM_RD-1:0]    rbusy,
  input  logic                 we0,
  input  logic [AW-1:0]        wa0,
  input  logic [DW-1:0]        wd0,
  input  logic                 we1,
  input  logic [AW-1:0]        wa1,
  input  logic [DW-1:0]        wd1,
  input  logic                 bset,
  input  logic [AW-1:0]        bset_a,
  output logic                 init_done
);

  localparam int unsigned DEPTH = 2**AW;
  localparam bit          ZR    = (ZERO_REG != 0);
  localparam logic [AW:0] LAST  = (AW+1)'(DEPTH - 1);

  state_e             state_q, state_d;
  logic [AW:0]        cnt_q, cnt_d;
  logic               init_done_q, init_done_d;
  logic [DW-1:0]      mem_q [DEPTH];
  logic [DW-1:0]      mem_d [DEPTH];
  logic [DEPTH-1:0]   busy_q, busy_d;
  logic               run;

  assign run       = (state_q == ST_RUN);
  assign init_done = init_done_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    mem_d       = mem_q;
    busy_d      = busy_q;
    case (state_q)
      ST_INIT: begin
        mem_d[cnt_q[AW-1:0]] = '0;
        cnt_d                = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (we0 && !(ZR && (wa0 == '0))) mem_d[wa0] = wd0;
        if (we1 && !(ZR && (wa1 == '0))) mem_d[wa1] = wd1;
        if (we0) busy_d[wa0] = 1'b0;
        if (we1) busy_d[wa1] = 1'b0;
        // Set after clear: a new issue outranks the writeback of the old one.
        if (bset) busy_d[bset_a] = 1'b1;
        if (ZR) busy_d[0] = 1'b0;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      busy_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      busy_q      <= busy_d;
    end
  end

  // Storage has no reset of its own; the sweep clears it after release.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= mem_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_rd_mux #(
      .DW       (DW),
      .AW       (AW),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_rd_mux (
      .run   (run),
      .ra    (ra[k*AW +: AW]),
      .mem   (mem_q),
      .busy  (busy_q),
      .we0   (we0),
      .wa0   (wa0),
      .wd0   (wd0),
      .we1   (we1),
      .wa1   (wa1),
      .wd1   (wd1),
      .rd    (rd[k*DW +: DW]),
      .rbusy (rbusy[k])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (bypass+zero-reg, and neither) against
// an array-based reference model, plus a directed vector table and init checks.
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [NR*AW-1:0]  ra;
  logic [NR*DW-1:0]  rd_a, rd_b;
  logic [NR-1:0]     rbusy_a, rbusy_b;
  logic              we0, we1, bset;
  logic [AW-1:0]     wa0, wa1, bset_a;
  logic [DW-1:0]     wd0, wd1;
  logic              init_done_a, init_done_b;

  regfile_mp #(.DW(DW), .AW(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)) u_dut_a (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd_a), .rbusy(rbusy_a),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .bset(bset), .bset_a(bset_a), .init_done(init_done_a)
  );

  regfile_mp #(.DW(DW), .AW(AW), .NUM_RD(NR), .ZERO_REG(0), .BYPASS(0)) u_dut_b (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd_b), .rbusy(rbusy_b),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .bset(bset), .bset_a(bset_a), .init_done(init_done_b)
  );

  // Reference model: cfg 0 = zero-reg + bypass, cfg 1 = plain.
  logic [DW-1:0] mdl_mem  [2][DEPTH];
  bit            mdl_busy [2][DEPTH];
  int            mdl_left = DEPTH;
  bit            chk_en   = 1'b0;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mdl_rd(input int c, input logic [AW-1:0] a);
    bit special;
    special = (c == 0);
    if (mdl_left != 0) return '0;
    if (special && a == 0) return '0;
    if (special && we1 && wa1 == a) return wd1;
    if (special && we0 && wa0 == a) return wd0;
    return mdl_mem[c][a];
  endfunction

  function automatic logic mdl_rb(input int c, input logic [AW-1:0] a);
    if (mdl_left != 0) return 1'b0;
    if (c == 0 && a == 0) return 1'b0;
    return mdl_busy[c][a];
  endfunction

  task automatic model_edge();
    if (!reset) begin
      mdl_left = DEPTH;
      for (int c = 0; c < 2; c++)
        for (int i = 0; i < DEPTH; i++) mdl_busy[c][i] = 1'b0;
    end else if (mdl_left > 0) begin
      for (int c = 0; c < 2; c++) mdl_mem[c][DEPTH - mdl_left] = '0;
      mdl_left--;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (we0 && !(c == 0 && wa0 == 0)) mdl_mem[c][wa0] = wd0;
        if (we1 && !(c == 0 && wa1 == 0)) mdl_mem[c][wa1] = wd1;
        if (we0) mdl_busy[c][wa0] = 1'b0;
        if (we1) mdl_busy[c][wa1] = 1'b0;
        if (bset) mdl_busy[c][bset_a] = 1'b1;
        if (c == 0) mdl_busy[c][0] = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    logic [AW-1:0] a;
    for (int k = 0; k < NR; k++) begin
      a = ra[k*AW +: AW];
      chk($sformatf("rd_a[%0d]", k), rd_a[k*DW +: DW], mdl_rd(0, a));
      chk($sformatf("rd_b[%0d]", k), rd_b[k*DW +: DW], mdl_rd(1, a));
      chk($sformatf("rbusy_a[%0d]", k), DW'(rbusy_a[k]), DW'(mdl_rb(0, a)));
      chk($sformatf("rbusy_b[%0d]", k), DW'(rbusy_b[k]), DW'(mdl_rb(1, a)));
    end
    chk("init_done_a", DW'(init_done_a), DW'(mdl_left == 0));
    chk("init_done_b", DW'(init_done_b), DW'(mdl_left == 0));
  endtask

  // Called just after a negedge with inputs set; returns at the next negedge.
  task automatic tick();
    #1;
    if (chk_en) check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input logic e0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic e1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic bs, input logic [AW-1:0] ba,
                       input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    we0 = e0; wa0 = a0; wd0 = d0;
    we1 = e1; wa1 = a1; wd1 = d1;
    bset = bs; bset_a = ba;
    ra = {r1, r0};
  endtask

  task automatic drive_rand(input int amax);
    drive(1'($urandom), AW'($urandom_range(0, amax)), $urandom,
          1'($urandom), AW'($urandom_range(0, amax)), $urandom,
          1'($urandom), AW'($urandom_range(0, amax)),
          AW'($urandom_range(0, amax)), AW'($urandom_range(0, amax)));
  endtask

  // Counts edges from reset release to init_done while hammering writes/bset on 5.
  task automatic wait_init(input string name);
    int n;
    n = 0;
    while (!init_done_a && n < 100) begin
      drive(1'b1, 5'd5, 32'hA5A5A5A5, 1'b1, 5'd5, 32'h5A5A5A5A, 1'b1, 5'd5, 5'd5, 5'd9);
      tick();
      n++;
    end
    chk(name, DW'(n), DW'(DEPTH));
  endtask

  typedef struct {
    logic          we0;
    logic [AW-1:0] wa0;
    logic [DW-1:0] wd0;
    logic          we1;
    logic [AW-1:0] wa1;
    logic [DW-1:0] wd1;
    logic          bset;
    logic [AW-1:0] bset_a;
    logic [AW-1:0] ra0;
    logic [DW-1:0] exp_rd0;
    logic          exp_rb0;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 32'h0,        1'b0};
    vecs[1]  = '{1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 32'hDEADBEEF, 1'b0};
    vecs[3]  = '{1'b1, 5'd7, 32'h11111111, 1'b1, 5'd7, 32'h22222222, 1'b0, 5'd0, 5'd7, 32'h22222222, 1'b0};
    vecs[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 32'h22222222, 1'b0};
    vecs[5]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 5'd0, 32'h0,        1'b0};
    vecs[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 32'h0,        1'b0};
    vecs[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 5'd9, 32'h0,        1'b0};
    vecs[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 32'h0,        1'b1};
    vecs[9]  = '{1'b1, 5'd9, 32'h12345678, 1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 5'd9, 32'h12345678, 1'b1};
    vecs[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 32'h12345678, 1'b1};
    vecs[11] = '{1'b1, 5'd9, 32'h0000ABCD, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 32'h0000ABCD, 1'b1};
    vecs[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 32'h0000ABCD, 1'b0};

    reset = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0, '0);
    @(negedge clk);
    tick();
    chk_en = 1'b1;
    tick();
    chk("reset init_done_a", DW'(init_done_a), '0);
    chk("reset rbusy_a", DW'(rbusy_a), '0);
    reset = 1'b1;
    wait_init("init latency");

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].we0, vecs[i].wa0, vecs[i].wd0, vecs[i].we1, vecs[i].wa1, vecs[i].wd1,
            vecs[i].bset, vecs[i].bset_a, vecs[i].ra0, AW'($urandom_range(0, DEPTH-1)));
      #1;
      chk($sformatf("vec%0d rd0", i), rd_a[0 +: DW], vecs[i].exp_rd0);
      chk($sformatf("vec%0d rbusy0", i), DW'(rbusy_a[0]), DW'(vecs[i].exp_rb0));
      tick();
    end

    // Leave some registers busy, then reset partway through the next sweep.
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd12, 5'd12, 5'd12);
    tick();
    reset = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, 5'd12, 5'd12);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_rand(DEPTH-1);
      tick();
    end
    reset = 1'b0;
    drive_rand(DEPTH-1);
    tick();
    chk("midsweep init_done", DW'(init_done_a), '0);
    reset = 1'b1;
    wait_init("restart latency");

    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, AW'(a), AW'(DEPTH-1-a));
      #1;
      chk($sformatf("busy clear r%0d", a), DW'(rbusy_a[0]), '0);
      tick();
    end

    for (int i = 0; i < 500; i++) begin
      reset = ($urandom_range(0, 249) != 0);
      drive_rand((i < 250) ? 7 : DEPTH-1);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
